// File: rtl/corefifo_fwft_prefetch_buf_if.sv
// Handshake bundle for the FWFT prefetch buffer: RAM read port on one side,
// consumer pop/status on the other.
interface corefifo_fwft_prefetch_buf_if #(
  parameter int RWIDTH = 32,
  parameter int CNT_W  = 3
);
  logic              fifo_empty;
  logic [RWIDTH-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              rd_en;
  logic [RWIDTH-1:0] dout;
  logic              empty;
  logic              aempty;
  logic [CNT_W-1:0]  level;
  logic              underflow;
  logic              clr_underflow;

  modport slave (
    input  fifo_empty, fifo_dout, rd_en, clr_underflow,
    output fifo_rd_en, dout, empty, aempty, level, underflow
  );

  modport master (
    output fifo_empty, fifo_dout, rd_en, clr_underflow,
    input  fifo_rd_en, dout, empty, aempty, level, underflow
  );
endinterface

// File: rtl/corefifo_fwft_prefetch_buf.sv
// First-word-fall-through output stage: credit-based skid buffer that absorbs
// the RAM read latency so the consumer can pop one word per cycle.
module corefifo_fwft_prefetch_buf #(
  parameter int RWIDTH        = 32,
  parameter int RD_LATENCY    = 1,
  parameter int SKID_DEPTH    = 4,
  parameter int CNT_W         = 3,
  parameter int AEMPTY_THRESH = 1,
  parameter int READ_LOW      = 0
) (
  input  logic                         clk,
  input  logic                         reset_rclk_top,
  corefifo_fwft_prefetch_buf_if.slave  bus
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [CNT_W:0] DEPTH_W  = (CNT_W+1)'(SKID_DEPTH);
  localparam logic [CNT_W:0] THRESH_W = (CNT_W+1)'(AEMPTY_THRESH);

  logic [RWIDTH-1:0]     mem [SKID_DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [CNT_W-1:0]      level_q;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic [RD_LATENCY-1:0] rd_pipe_next;
  logic                  underflow_q;

  logic                  re_p;
  logic                  pop;
  logic                  capture;
  logic                  empty_int;
  logic                  credit_ok;
  logic [CNT_W:0]        inflight;
  logic [CNT_W:0]        occupied;
  logic [CNT_W:0]        room;

  assign re_p      = (READ_LOW != 0) ? ~bus.rd_en : bus.rd_en;
  assign empty_int = (level_q == '0);
  assign pop       = re_p & ~empty_int;
  assign capture   = rd_pipe[RD_LATENCY-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + (CNT_W+1)'(rd_pipe[i]);
    end
  end

  // credit > 0 rewritten as an unsigned compare: level + inflight < depth + pop
  assign occupied  = {1'b0, level_q} + inflight;
  assign room      = DEPTH_W + (CNT_W+1)'(pop);
  assign credit_ok = (occupied < room);

  assign bus.fifo_rd_en = reset_rclk_top & ~bus.fifo_empty & credit_ok;

  always_comb begin
    rd_pipe_next    = rd_pipe << 1;
    rd_pipe_next[0] = bus.fifo_rd_en;
  end

  always_ff @(posedge clk or negedge reset_rclk_top) begin
    if (!reset_rclk_top) begin
      rd_pipe     <= '0;
      wptr        <= '0;
      rptr        <= '0;
      level_q     <= '0;
      underflow_q <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      rd_pipe <= rd_pipe_next;
      if (capture) begin
        mem[wptr] <= bus.fifo_dout;
        wptr      <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      level_q <= level_q + CNT_W'(capture) - CNT_W'(pop);
      // a new underflow takes priority over a coincident clear
      underflow_q <= (re_p & empty_int) | (underflow_q & ~bus.clr_underflow);
    end
  end

  assign bus.dout      = mem[rptr];
  assign bus.empty     = empty_int;
  assign bus.level     = level_q;
  assign bus.aempty    = ({1'b0, level_q} <= THRESH_W);
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_corefifo_fwft_prefetch_buf.sv
// Directed bench for the FWFT prefetch buffer: instance A uses 1-cycle RAM
// latency, instance B uses 2-cycle latency with active-low pop.
module tb_corefifo_fwft_prefetch_buf;

  logic clk = 1'b0;
  logic reset_rclk_top;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  corefifo_fwft_prefetch_buf_if #(.RWIDTH(32), .CNT_W(3)) bus_a ();
  corefifo_fwft_prefetch_buf_if #(.RWIDTH(32), .CNT_W(3)) bus_b ();

  corefifo_fwft_prefetch_buf #(
    .RWIDTH(32), .RD_LATENCY(1), .SKID_DEPTH(4), .CNT_W(3),
    .AEMPTY_THRESH(2), .READ_LOW(0)
  ) dut_a (
    .clk(clk), .reset_rclk_top(reset_rclk_top), .bus(bus_a)
  );

  corefifo_fwft_prefetch_buf #(
    .RWIDTH(32), .RD_LATENCY(2), .SKID_DEPTH(4), .CNT_W(3),
    .AEMPTY_THRESH(1), .READ_LOW(1)
  ) dut_b (
    .clk(clk), .reset_rclk_top(reset_rclk_top), .bus(bus_b)
  );

  // RAM models: head advances on each strobe, empty when head reaches limit
  logic [31:0] ram_a [16];
  logic [31:0] ram_b [16];
  logic [4:0]  a_head = '0;
  logic [4:0]  b_head = '0;
  logic [4:0]  a_limit;
  logic [4:0]  b_limit;
  logic [31:0] a_dout = '0;
  logic [31:0] b_d1   = '0;
  logic [31:0] b_dout = '0;

  assign bus_a.fifo_empty = (a_head == a_limit);
  assign bus_a.fifo_dout  = a_dout;
  assign bus_b.fifo_empty = (b_head == b_limit);
  assign bus_b.fifo_dout  = b_dout;

  always @(posedge clk) begin
    if (bus_a.fifo_rd_en) begin
      a_dout <= ram_a[a_head[3:0]];
      a_head <= a_head + 5'd1;
    end
    if (bus_b.fifo_rd_en) begin
      b_d1   <= ram_b[b_head[3:0]];
      b_head <= b_head + 5'd1;
    end
    b_dout <= b_d1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_rclk_top = 1'b0;
    a_limit = 5'd0;
    b_limit = 5'd0;
    bus_a.rd_en = 1'b0;
    bus_a.clr_underflow = 1'b0;
    bus_b.rd_en = 1'b1;
    bus_b.clr_underflow = 1'b0;
    tick();
    tick();
    n_tests++; if (bus_a.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty_a: got %0b expected 1", bus_a.empty); end
    n_tests++; if (bus_a.aempty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_aempty_a: got %0b expected 1", bus_a.aempty); end
    n_tests++; if (bus_a.level !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_level_a: got %0d expected 0", bus_a.level); end
    n_tests++; if (bus_a.underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_underflow_a: got %0b expected 0", bus_a.underflow); end
    n_tests++; if (bus_a.dout !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_dout_a: got %0h expected 0", bus_a.dout); end
    n_tests++; if (bus_b.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty_b: got %0b expected 1", bus_b.empty); end
    n_tests++; if (bus_b.aempty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_aempty_b: got %0b expected 1", bus_b.aempty); end
    n_tests++; if (bus_b.underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_underflow_b: got %0b expected 0", bus_b.underflow); end
    a_limit = 5'd8;
    #1;
    n_tests++; if (bus_a.fifo_rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_en_forced: got %0b expected 0", bus_a.fifo_rd_en); end
  endtask

  task automatic test_first_word();
    @(posedge clk);
    #1;
    reset_rclk_top = 1'b1;
    #1;
    n_tests++; if (bus_a.fifo_rd_en !== 1'b1) begin n_fail++; $display("[TB] FAIL fw_c0_rd_en: got %0b expected 1", bus_a.fifo_rd_en); end
    n_tests++; if (bus_a.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL fw_c0_empty: got %0b expected 1", bus_a.empty); end
    tick();
    n_tests++; if (bus_a.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL fw_c1_empty: got %0b expected 1", bus_a.empty); end
    n_tests++; if (bus_a.fifo_rd_en !== 1'b1) begin n_fail++; $display("[TB] FAIL fw_c1_rd_en: got %0b expected 1", bus_a.fifo_rd_en); end
    tick();
    n_tests++; if (bus_a.empty !== 1'b0) begin n_fail++; $display("[TB] FAIL fw_c2_empty: got %0b expected 0", bus_a.empty); end
    n_tests++; if (bus_a.dout !== 32'hA0) begin n_fail++; $display("[TB] FAIL fw_c2_dout: got %0h expected a0", bus_a.dout); end
    n_tests++; if (bus_a.level !== 3'd1) begin n_fail++; $display("[TB] FAIL fw_c2_level: got %0d expected 1", bus_a.level); end
    tick();
    tick();
    n_tests++; if (bus_a.level !== 3'd3) begin n_fail++; $display("[TB] FAIL fw_c4_level: got %0d expected 3", bus_a.level); end
    n_tests++; if (bus_a.fifo_rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL fw_c4_credit_stop: got %0b expected 0", bus_a.fifo_rd_en); end
    tick();
    n_tests++; if (bus_a.level !== 3'd4) begin n_fail++; $display("[TB] FAIL fw_c5_level: got %0d expected 4", bus_a.level); end
    n_tests++; if (bus_a.fifo_rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL fw_c5_rd_en: got %0b expected 0", bus_a.fifo_rd_en); end
    n_tests++; if (bus_a.dout !== 32'hA0) begin n_fail++; $display("[TB] FAIL fw_c5_dout: got %0h expected a0", bus_a.dout); end
  endtask

  task automatic test_aempty();
    logic [2:0] exp_lvl [5];
    logic       exp_ae  [5];
    exp_lvl = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    exp_ae  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    a_limit = 5'd4;
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (bus_a.level !== exp_lvl[k]) begin n_fail++; $display("[TB] FAIL ae_level[%0d]: got %0d expected %0d", k, bus_a.level, exp_lvl[k]); end
      n_tests++; if (bus_a.aempty !== exp_ae[k]) begin n_fail++; $display("[TB] FAIL ae_flag[%0d]: got %0b expected %0b", k, bus_a.aempty, exp_ae[k]); end
      if (k < 4) begin
        n_tests++; if (bus_a.dout !== 32'hA0 + 32'(k)) begin n_fail++; $display("[TB] FAIL ae_dout[%0d]: got %0h expected %0h", k, bus_a.dout, 32'hA0 + 32'(k)); end
        bus_a.rd_en = 1'b1;
        tick();
      end else begin
        bus_a.rd_en = 1'b0;
        n_tests++; if (bus_a.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL ae_drained_empty: got %0b expected 1", bus_a.empty); end
      end
    end
  endtask

  task automatic test_underflow();
    bus_a.rd_en = 1'b1;
    tick();
    bus_a.rd_en = 1'b0;
    n_tests++; if (bus_a.underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_set: got %0b expected 1", bus_a.underflow); end
    n_tests++; if (bus_a.level !== 3'd0) begin n_fail++; $display("[TB] FAIL uf_level: got %0d expected 0", bus_a.level); end
    bus_a.clr_underflow = 1'b1;
    tick();
    bus_a.clr_underflow = 1'b0;
    n_tests++; if (bus_a.underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_clear: got %0b expected 0", bus_a.underflow); end
    bus_a.rd_en = 1'b1;
    bus_a.clr_underflow = 1'b1;
    tick();
    bus_a.rd_en = 1'b0;
    bus_a.clr_underflow = 1'b0;
    n_tests++; if (bus_a.underflow !== 1'b1) begin n_fail++; $display("[TB] FAIL uf_set_wins: got %0b expected 1", bus_a.underflow); end
    bus_a.clr_underflow = 1'b1;
    tick();
    bus_a.clr_underflow = 1'b0;
    n_tests++; if (bus_a.underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL uf_clear2: got %0b expected 0", bus_a.underflow); end
  endtask

  task automatic test_level_one();
    a_limit = 5'd6;
    #1;
    n_tests++; if (bus_a.fifo_rd_en !== 1'b1) begin n_fail++; $display("[TB] FAIL l1_rd_en: got %0b expected 1", bus_a.fifo_rd_en); end
    tick();
    tick();
    n_tests++; if (bus_a.level !== 3'd1) begin n_fail++; $display("[TB] FAIL l1_level_before: got %0d expected 1", bus_a.level); end
    n_tests++; if (bus_a.dout !== 32'hA4) begin n_fail++; $display("[TB] FAIL l1_dout_before: got %0h expected a4", bus_a.dout); end
    bus_a.rd_en = 1'b1;
    tick();
    n_tests++; if (bus_a.level !== 3'd1) begin n_fail++; $display("[TB] FAIL l1_level_pop_capture: got %0d expected 1", bus_a.level); end
    n_tests++; if (bus_a.dout !== 32'hA5) begin n_fail++; $display("[TB] FAIL l1_dout_advance: got %0h expected a5", bus_a.dout); end
    tick();
    bus_a.rd_en = 1'b0;
    n_tests++; if (bus_a.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL l1_empty_after_pop: got %0b expected 1", bus_a.empty); end
    n_tests++; if (bus_a.underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL l1_no_underflow: got %0b expected 0", bus_a.underflow); end
  endtask

  task automatic test_reset_midstream();
    a_limit = 5'd16;
    #1;
    tick();
    tick();
    tick();
    tick();
    n_tests++; if (bus_a.level !== 3'd3) begin n_fail++; $display("[TB] FAIL rm_level_before: got %0d expected 3", bus_a.level); end
    #2;
    reset_rclk_top = 1'b0;
    #1;
    n_tests++; if (bus_a.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL rm_async_empty: got %0b expected 1", bus_a.empty); end
    n_tests++; if (bus_a.level !== 3'd0) begin n_fail++; $display("[TB] FAIL rm_async_level: got %0d expected 0", bus_a.level); end
    n_tests++; if (bus_a.fifo_rd_en !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_async_rd_en: got %0b expected 0", bus_a.fifo_rd_en); end
    tick();
    reset_rclk_top = 1'b1;
    #1;
    n_tests++; if (bus_a.fifo_rd_en !== 1'b1) begin n_fail++; $display("[TB] FAIL rm_restart_rd_en: got %0b expected 1", bus_a.fifo_rd_en); end
    n_tests++; if (bus_a.dout !== 32'h0) begin n_fail++; $display("[TB] FAIL rm_no_stale_dout: got %0h expected 0", bus_a.dout); end
    tick();
    tick();
    n_tests++; if (bus_a.empty !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_refill_empty: got %0b expected 0", bus_a.empty); end
    n_tests++; if (bus_a.dout !== 32'hAA) begin n_fail++; $display("[TB] FAIL rm_refill_dout: got %0h expected aa", bus_a.dout); end
  endtask

  task automatic test_back_to_back();
    b_limit = 5'd16;
    #1;
    n_tests++; if (bus_b.fifo_rd_en !== 1'b1) begin n_fail++; $display("[TB] FAIL bb_c0_rd_en: got %0b expected 1", bus_b.fifo_rd_en); end
    tick();
    tick();
    n_tests++; if (bus_b.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL bb_c2_empty: got %0b expected 1", bus_b.empty); end
    tick();
    n_tests++; if (bus_b.empty !== 1'b0) begin n_fail++; $display("[TB] FAIL bb_c3_empty: got %0b expected 0", bus_b.empty); end
    bus_b.rd_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_tests++; if (bus_b.empty !== 1'b0) begin n_fail++; $display("[TB] FAIL bb_stream_empty[%0d]: got %0b expected 0", k, bus_b.empty); end
      n_tests++; if (bus_b.dout !== 32'(k)) begin n_fail++; $display("[TB] FAIL bb_stream_dout[%0d]: got %0h expected %0h", k, bus_b.dout, k); end
      tick();
    end
    n_tests++; if (bus_b.empty !== 1'b1) begin n_fail++; $display("[TB] FAIL bb_end_empty: got %0b expected 1", bus_b.empty); end
    n_tests++; if (bus_b.level !== 3'd0) begin n_fail++; $display("[TB] FAIL bb_end_level: got %0d expected 0", bus_b.level); end
    bus_b.rd_en = 1'b1;
    n_tests++; if (bus_b.underflow !== 1'b0) begin n_fail++; $display("[TB] FAIL bb_no_underflow: got %0b expected 0", bus_b.underflow); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram_a[i] = 32'hA0 + 32'(i);
      ram_b[i] = 32'(i);
    end
    test_reset();
    test_first_word();
    test_aempty();
    test_underflow();
    test_level_one();
    test_reset_midstream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule

// File: doc/corefifo_fwft_prefetch_buf.md
Name: corefifo_fwft_prefetch_buf

Overview:
- Parametrised first-word-fall-through output stage placed between a CoreFIFO RAM read port and a downstream consumer, such as a DDR arbiter read or write channel.
- Replaces the fixed three-register prefetch with an N-entry credit-based skid buffer.
- Supports a configurable RAM read latency (1 or 2) and selectable read-enable polarity.
- Adds an occupancy count, a programmable almost-empty threshold and a sticky underflow flag.

Parameters:
- RWIDTH, 32, data width of fifo_dout and dout.
- RD_LATENCY, 1, cycles from fifo_rd_en sampled to fifo_dout valid. Legal values: 1, 2.
- SKID_DEPTH, 4, buffer entries. Power of 2, and at least RD_LATENCY+1.
- CNT_W, 3, width of the level output. Equals log2(SKID_DEPTH)+1.
- AEMPTY_THRESH, 1, aempty asserts when level <= this value. Legal range 0..SKID_DEPTH.
- READ_LOW, 0, 1 selects active-low rd_en.

Ports:
- clk, input, 1, single clock, rising edge.
- reset_rclk_top, input, 1, asynchronous active-low reset.
- fifo_empty, input, 1, RAM FIFO empty flag.
- fifo_dout, input, RWIDTH, RAM read data, valid RD_LATENCY cycles after a sampled fifo_rd_en.
- fifo_rd_en, output, 1, active-high RAM read strobe. Combinational.
- rd_en, input, 1, consumer pop request. Polarity is set by READ_LOW.
- dout, output, RWIDTH, head-of-buffer data.
- empty, output, 1, high when no valid word is on dout.
- aempty, output, 1, level <= AEMPTY_THRESH.
- level, output, CNT_W, number of words held in the buffer, 0..SKID_DEPTH.
- underflow, output, 1, sticky. Set when a pop is requested while empty.
- clr_underflow, input, 1, synchronous clear of underflow.

Behaviour:
- Reset is asynchronous and active-low on reset_rclk_top; all state is cleared. Reset values:
  - empty=1, aempty=1 (level 0 <= any legal threshold), level=0, underflow=0, dout=0.
  - In-flight pipe cleared, read/write pointers 0.
  - fifo_rd_en is forced low while in reset.
- re_p = READ_LOW ? ~rd_en : rd_en.
- pop = re_p & ~empty.
- Flow control:
  - inflight = number of set bits in an RD_LATENCY-deep shift register. Bit 0 is loaded with fifo_rd_en each cycle.
  - credit = SKID_DEPTH - level - inflight + pop.
  - fifo_rd_en = ~fifo_empty & (credit > 0).
  - The buffer never overflows by construction. An overflow condition is an assertion failure in verification.
- Capture:
  - When the shift-register output bit is 1, fifo_dout is written to mem[wptr] and wptr increments, wrapping modulo SKID_DEPTH.
- Output:
  - dout = mem[rptr], driven from registers; there is no combinational path from fifo_dout.
  - empty = (level == 0).
  - pop increments rptr, wrapping modulo SKID_DEPTH.
- Level update, per cycle: level_next = level + capture - pop.
  - Simultaneous capture and pop leaves level unchanged.
  - Capture and pop may both occur when level == 1: the new word is visible on dout the next cycle.
- First-word latency:
  - If fifo_empty falls in cycle t with the buffer empty, fifo_rd_en is high in cycle t.
  - Capture occurs at the end of cycle t+RD_LATENCY.
  - empty falls in cycle t+RD_LATENCY+1.
- Throughput: with fifo_empty low and rd_en held active, one word is popped per cycle with no bubbles, provided SKID_DEPTH >= RD_LATENCY+1.
- Underflow:
  - re_p & empty sets underflow on the next edge.
  - clr_underflow clears it. If set and clear coincide, set wins.
  - Pointers and level are unaffected by an underflow.
- aempty and level are combinational from registered level.
- Reset asserted mid-burst: in-flight RAM reads are discarded. The upstream FIFO is reset by the same reset_rclk_top.

Test Plan:
- Reset, then fifo_empty=0 with RAM words 0xA0..0xA7 and RD_LATENCY=1 -> fifo_rd_en high in cycle 0, empty low in cycle 2, dout=0xA0, level rises to 4, and fifo_rd_en drops once level+inflight reaches 4.
- Continuous pop, SKID_DEPTH=4, RD_LATENCY=2, 16 words -> dout sequence is 0..15 with one word per cycle and empty never asserting mid-stream. Repeat with READ_LOW=1 and rd_en low.
- Pop when level==1 while a capture lands in the same cycle -> level stays 1 and dout advances to the next word. Pop with no capture -> empty=1 the next cycle.
- AEMPTY_THRESH=2, fill to 4 then pop one per cycle -> aempty is 0,0,1,1,1 for level 4,3,2,1,0.
- rd_en active while empty -> underflow=1 the next cycle and level stays 0. clr_underflow pulse -> 0. Simultaneous set and clear -> 1.
- Assert reset_rclk_top low asynchronously mid-stream with level=3 -> empty=1, level=0 and fifo_rd_en=0 immediately. After release, refill restarts from the current RAM head with no stale word on dout.
